// File: rtl/timer_sched.sv
// timer_sched: one free-running prescaler producing a base tick shared by
// NCH independent countdown channels (one-shot or periodic).
module timer_sched #(
  parameter int unsigned PRESCALE = 500_000,
  parameter int unsigned NCH      = 4,
  parameter int unsigned CW       = 16,
  localparam int unsigned CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_period,
  input  logic           cfg_mode,
  input  logic [NCH-1:0] start,
  input  logic [NCH-1:0] stop,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] expire,
  output logic           base_tick
);

  localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  logic [PW-1:0]  presc_q;
  logic [PW-1:0]  presc_d;
  logic           tick_q;
  logic           tick_d;

  logic [CW-1:0]  period_q [NCH];
  logic [NCH-1:0] mode_q;

  state_e         state_q  [NCH];
  state_e         state_d  [NCH];
  logic [CW-1:0]  rem_q    [NCH];
  logic [CW-1:0]  rem_d    [NCH];
  logic [NCH-1:0] expire_q;
  logic [NCH-1:0] expire_d;

  // Prescaler next count and tick: tick registers the terminal count.
  always_comb begin
    presc_d = presc_q + PW'(1);
    tick_d  = 1'b0;
    if (presc_q == PW'(PRESCALE - 1)) begin
      presc_d = '0;
      tick_d  = 1'b1;
    end
  end

  // Prescaler counter and base tick register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  // Per-channel configuration registers; loads in the same cycle see old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        period_q[i] <= '0;
      end
      mode_q <= '0;
    end else if (cfg_we) begin
      for (int i = 0; i < NCH; i++) begin
        if (cfg_ch == CHW'(i)) begin
          period_q[i] <= cfg_period;
          mode_q[i]   <= cfg_mode;
        end
      end
    end
  end

  // Channel next-state: stop beats start, start beats the base tick.
  always_comb begin
    expire_d = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      rem_d[i]   = rem_q[i];
      case (state_q[i])
        IDLE: begin
          if (!stop[i] && start[i] && (period_q[i] != '0)) begin
            state_d[i] = RUN;
            rem_d[i]   = period_q[i];
          end
        end
        RUN: begin
          if (stop[i]) begin
            state_d[i] = IDLE;
          end else begin
            // A terminal tick still expires even when a restart lands on it.
            if (tick_q && (rem_q[i] == CW'(1))) begin
              expire_d[i] = 1'b1;
            end
            if (start[i]) begin
              rem_d[i] = period_q[i];
              if (period_q[i] == '0) begin
                state_d[i] = IDLE;
              end
            end else if (tick_q) begin
              if (rem_q[i] > CW'(1)) begin
                rem_d[i] = rem_q[i] - CW'(1);
              end else if (mode_q[i] && (period_q[i] != '0)) begin
                rem_d[i] = period_q[i];
              end else begin
                state_d[i] = IDLE;
              end
            end
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // Channel state, remaining count and expire pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= IDLE;
        rem_q[i]   <= '0;
      end
      expire_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        rem_q[i]   <= rem_d[i];
      end
      expire_q <= expire_d;
    end
  end

  // Busy mirrors the registered channel state.
  always_comb begin
    busy = '0;
    for (int i = 0; i < NCH; i++) begin
      busy[i] = (state_q[i] == RUN);
    end
  end

  assign expire    = expire_q;
  assign base_tick = tick_q;

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched with PRESCALE=4, NCH=4, CW=16.
module tb_timer_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_period;
  logic        cfg_mode;
  logic [3:0]  start;
  logic [3:0]  stop;
  logic [3:0]  busy;
  logic [3:0]  expire;
  logic        base_tick;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  timer_sched #(
    .PRESCALE(4),
    .NCH(4),
    .CW(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_period(cfg_period),
    .cfg_mode(cfg_mode),
    .start(start),
    .stop(stop),
    .busy(busy),
    .expire(expire),
    .base_tick(base_tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    rst_n      = 1'b1;
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_period = '0;
    cfg_mode   = 1'b0;
    start      = '0;
    stop       = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_expire", 32'(expire), 32'h0);
    chk("rst_tick", 32'(base_tick), 32'h0);
    repeat (3) @(posedge clk);
    #4 rst_n = 1'b1;
    cyc = 0;
    #1;
    chk("rel_busy", 32'(busy), 32'h0);
    chk("rel_expire", 32'(expire), 32'h0);

    // Prescaler: tick after edges 4, 8, ... one cycle wide
    goto(3); chk("tick_c3", 32'(base_tick), 32'h0);
    goto(4); chk("tick_c4", 32'(base_tick), 32'h1);
    goto(5); chk("tick_c5", 32'(base_tick), 32'h0);
    goto(8); chk("tick_c8", 32'(base_tick), 32'h1);

    // One-shot ch0 period 3
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = 16'd3; cfg_mode = 1'b0;
    step();
    cfg_we = 1'b0; start = 4'b0001;
    step();
    start = '0;
    chk("os_busy_start", 32'(busy[0]), 32'h1);
    chk("os_exp_start", 32'(expire[0]), 32'h0);
    goto(20);
    chk("os_tick3", 32'(base_tick), 32'h1);
    chk("os_exp_early", 32'(expire[0]), 32'h0);
    chk("os_busy_early", 32'(busy[0]), 32'h1);
    goto(21);
    chk("os_expire", 32'(expire[0]), 32'h1);
    chk("os_busy_fall", 32'(busy[0]), 32'h0);
    repeat (40) begin
      step();
      chk("os_no_more", 32'(expire[0]), 32'h0);
    end

    // Periodic ch1 period 2: expire every 8 cycles, then stop
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_period = 16'd2; cfg_mode = 1'b1;
    step();
    cfg_we = 1'b0; start = 4'b0010;
    step();
    start = '0;
    chk("per_busy", 32'(busy[1]), 32'h1);
    repeat (30) begin
      step();
      chk("per_busy", 32'(busy[1]), 32'h1);
      chk("per_expire", 32'(expire[1]), 32'((cyc >= 69) && (((cyc - 69) % 8) == 0)));
    end
    stop = 4'b0010;
    step();
    stop = '0;
    chk("per_stop_busy", 32'(busy[1]), 32'h0);
    repeat (26) begin
      step();
      chk("per_stop_exp", 32'(expire[1]), 32'h0);
    end

    // Stop on a tick cycle beats expiry; start with zero period ignored
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_period = 16'd1; cfg_mode = 1'b1;
    step();
    cfg_we = 1'b0; start = 4'b0100;
    step();
    start = '0;
    chk("ch2_busy", 32'(busy[2]), 32'h1);
    goto(124);
    chk("ch2_tick", 32'(base_tick), 32'h1);
    stop = 4'b0100;
    step();
    stop = '0;
    chk("ch2_stop_exp", 32'(expire[2]), 32'h0);
    chk("ch2_stop_busy", 32'(busy[2]), 32'h0);
    start = 4'b1000;
    repeat (5) begin
      step();
      chk("ch3_zero_per", 32'(busy[3]), 32'h0);
    end
    start = '0;

    // Period change mid-interval applies at the next reload
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = 16'd2; cfg_mode = 1'b1;
    step();
    cfg_we = 1'b0; start = 4'b0001;
    step();
    start = '0;
    goto(137);
    chk("chg_first", 32'(expire[0]), 32'h1);
    goto(139);
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = 16'd5; cfg_mode = 1'b1;
    step();
    cfg_we = 1'b0;
    chk("chg_exp", 32'(expire[0]), 32'h0);
    repeat (30) begin
      step();
      chk("chg_exp", 32'(expire[0]), 32'((cyc == 145) || (cyc == 165)));
    end

    // Async reset mid-interval clears everything, including config
    start = 4'b0010;
    step();
    start = '0;
    goto(174);
    chk("pre_rst_busy", 32'(busy), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 32'h0);
    chk("async_expire", 32'(expire), 32'h0);
    chk("async_tick", 32'(base_tick), 32'h0);
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    cyc = 0;
    goto(4);
    chk("post_rst_tick", 32'(base_tick), 32'h1);
    start = 4'b0011;
    step();
    start = '0;
    repeat (30) begin
      step();
      chk("post_rst_exp", 32'(expire), 32'h0);
      chk("post_rst_busy", 32'(busy), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
